// File: rtl/mac4_accum_if.sv
// Operand/result handshake bundle for mac4_accum. The producer/consumer side
// drives master; the accumulator itself sits on slave.
interface mac4_accum_if;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;

    modport master (
        output clr, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  clr, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/mac4_accum.sv
// Sums N consecutive 4x4 unsigned products into a 12-bit total, with an
// operand register stage ahead of the multiplier and a held result port.

module mul4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0][7:0] pp;
    logic [4:0][7:0] psum;

    assign psum[0] = 8'd0;

    // One shifted partial-product row per multiplier bit, rippled together.
    for (genvar i = 0; i < 4; i++) begin : g_row
        assign pp[i]     = b[i] ? (8'({4'b0, a}) << i) : 8'd0;
        assign psum[i+1] = psum[i] + pp[i];
    end

    assign p = psum[4];
endmodule

module mac4_accum #(
    parameter int N = 8
) (
    input logic        clk,
    input logic        rst,
    mac4_accum_if.slave bus
);
    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s1_last_q, s1_last_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic [11:0] acc_q, acc_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  prod;
    logic        accept;

    mul4 u_mul (.a(a_q), .b(b_q), .p(prod));

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s1_valid_d = 1'b0;
        s1_last_d  = 1'b0;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = s1_valid_q ? acc_q + {4'b0, prod} : acc_q;

        case (state_q)
            ACC: begin
                if (accept) begin
                    a_d        = bus.in_a;
                    b_d        = bus.in_b;
                    s1_valid_d = 1'b1;
                    if (cnt_q == 4'(N - 1)) begin
                        cnt_d     = 4'd0;
                        s1_last_d = 1'b1;
                        state_d   = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            // The final product is still in stage 1 here and always carries s1_last.
            DRAIN: if (s1_last_q) state_d = HOLD;
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACC;
                    acc_d   = 12'd0;
                end
            end
            default: state_d = ACC;
        endcase

        if (bus.clr) begin
            state_d    = ACC;
            cnt_d      = 4'd0;
            s1_valid_d = 1'b0;
            s1_last_d  = 1'b0;
            acc_d      = 12'd0;
        end

        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            cnt_q       <= 4'd0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            acc_q       <= 12'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;
endmodule

// File: tb/tb_mac4_accum.sv
// Bench for mac4_accum: three instances (N = 4, 8, 16) driven with directed
// groups, checked every cycle against a group-level model and literal sums.
module tb_mac4_accum;
    localparam int NI = 3;

    function automatic int nv(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 8 : 16);
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        clr_v[NI];
    logic        in_valid_v[NI];
    logic [3:0]  in_a_v[NI];
    logic [3:0]  in_b_v[NI];
    logic        out_ready_v[NI];
    logic        in_ready_v[NI];
    logic        out_valid_v[NI];
    logic [11:0] out_sum_v[NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mac4_accum_if ifc ();
        assign ifc.clr       = clr_v[g];
        assign ifc.in_valid  = in_valid_v[g];
        assign ifc.in_a      = in_a_v[g];
        assign ifc.in_b      = in_b_v[g];
        assign ifc.out_ready = out_ready_v[g];
        assign in_ready_v[g]  = ifc.in_ready;
        assign out_valid_v[g] = ifc.out_valid;
        assign out_sum_v[g]   = ifc.out_sum;
        mac4_accum #(.N((g == 0) ? 4 : ((g == 1) ? 8 : 16))) dut (
            .clk(clk),
            .rst(rst),
            .bus(ifc)
        );
    end

    // Group-level model: phase 0 = taking pairs, 1 = last product in flight,
    // 2 = result offered. m_sum is the exact running total of products.
    int m_cnt[NI];
    int m_sum[NI];
    int m_ph[NI];

    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < NI; g++) begin
            if (rst || clr_v[g]) begin
                m_cnt[g] <= 0;
                m_sum[g] <= 0;
                m_ph[g]  <= 0;
            end else if (m_ph[g] == 0) begin
                if (in_valid_v[g]) begin
                    m_sum[g] <= m_sum[g] + int'(in_a_v[g]) * int'(in_b_v[g]);
                    if (m_cnt[g] + 1 == nv(g)) begin
                        m_cnt[g] <= 0;
                        m_ph[g]  <= 1;
                    end else begin
                        m_cnt[g] <= m_cnt[g] + 1;
                    end
                end
            end else if (m_ph[g] == 1) begin
                m_ph[g] <= 2;
            end else if (out_ready_v[g]) begin
                m_ph[g]  <= 0;
                m_sum[g] <= 0;
            end
        end
    end

    typedef struct {
        int g;
        int v;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    task automatic check(input string name, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=%0d expected=%0d t=%0t", name, g, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            check("results_outstanding", 0, exp_q.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end else begin
            for (int g = 0; g < NI; g++) begin
                if (rst) begin
                    check("rst_out_valid", g, int'(out_valid_v[g]), 0);
                    check("rst_out_sum", g, int'(out_sum_v[g]), 0);
                    check("rst_in_ready", g, int'(in_ready_v[g]), 1);
                end else begin
                    check("in_ready", g, int'(in_ready_v[g]), int'(m_ph[g] == 0));
                    check("out_valid", g, int'(out_valid_v[g]), int'(m_ph[g] == 2));
                    if (m_ph[g] == 2) begin
                        check("out_sum_model", g, int'(out_sum_v[g]), m_sum[g]);
                        if (out_ready_v[g]) begin
                            if (exp_q.size() == 0) begin
                                check("unexpected_result", g, 1, 0);
                            end else begin
                                exp_t e;
                                e = exp_q.pop_front();
                                check("result_inst", g, g, e.g);
                                check("out_sum_literal", g, int'(out_sum_v[g]), e.v);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic expect_sum(input int g, input int v);
        exp_t e;
        e.g = g;
        e.v = v;
        exp_q.push_back(e);
    endtask

    // Holds the pair until the DUT takes it; returns #1 after the accepting edge.
    task automatic send(input int g, input logic [3:0] a, input logic [3:0] b);
        logic ok;
        int   t;
        t = 0;
        in_valid_v[g] = 1'b1;
        in_a_v[g] = a;
        in_b_v[g] = b;
        do begin
            @(negedge clk);
            ok = in_ready_v[g];
            @(posedge clk);
            #1;
            t++;
            if (t > 100) begin
                $display("FAIL send_timeout inst=%0d", g);
                $fatal(1, "send timeout");
            end
        end while (!ok);
        in_valid_v[g] = 1'b0;
    endtask

    task automatic wait_valid(input int g);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
            if (t > 100) begin
                $display("FAIL result_timeout inst=%0d", g);
                $fatal(1, "result timeout");
            end
        end while (!out_valid_v[g]);
    endtask

    task automatic wait_taken(input int g);
        out_ready_v[g] = 1'b1;
        wait_valid(g);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous pulse straddling a falling edge, away from the rising edge.
    task automatic pulse_rst();
        @(posedge clk);
        #3 rst = 1'b1;
        #4 rst = 1'b0;
        #4;
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            clr_v[g] = 1'b0;
            in_valid_v[g] = 1'b0;
            in_a_v[g] = 4'd0;
            in_b_v[g] = 4'd0;
            out_ready_v[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic group: 4 x 15*15 = 900.
        out_ready_v[0] = 1'b1;
        expect_sum(0, 900);
        repeat (4) send(0, 4'd15, 4'd15);
        wait_taken(0);

        // Mixed operands: 2 + 12 + 0 + 63 = 77.
        expect_sum(0, 77);
        send(0, 4'd1, 4'd2);
        send(0, 4'd3, 4'd4);
        send(0, 4'd0, 4'd15);
        send(0, 4'd7, 4'd9);
        wait_taken(0);

        // Backpressure: result held, pending pair not consumed, next group from 0.
        out_ready_v[0] = 1'b0;
        expect_sum(0, 900);
        repeat (4) send(0, 4'd15, 4'd15);
        wait_valid(0);
        in_valid_v[0] = 1'b1;
        in_a_v[0] = 4'd5;
        in_b_v[0] = 4'd5;
        repeat (5) @(posedge clk);
        #1 out_ready_v[0] = 1'b1;
        expect_sum(0, 28);
        send(0, 4'd5, 4'd5);
        repeat (3) send(0, 4'd1, 4'd1);
        wait_taken(0);

        // Maximum total then counter wrap into a second group.
        out_ready_v[2] = 1'b1;
        expect_sum(2, 3600);
        expect_sum(2, 16);
        repeat (16) send(2, 4'd15, 4'd15);
        repeat (16) send(2, 4'd1, 4'd1);
        wait_taken(2);

        // Abort mid-group with a pair offered during clr: only 8 x 6 = 48 emerges.
        out_ready_v[1] = 1'b1;
        repeat (3) send(1, 4'd15, 4'd15);
        clr_v[1] = 1'b1;
        in_valid_v[1] = 1'b1;
        in_a_v[1] = 4'd15;
        in_b_v[1] = 4'd15;
        @(posedge clk);
        #1;
        clr_v[1] = 1'b0;
        in_valid_v[1] = 1'b0;
        expect_sum(1, 48);
        repeat (8) send(1, 4'd2, 4'd3);
        wait_taken(1);

        // Reset mid-group, then reset while a result is held; neither emits.
        repeat (3) send(1, 4'd1, 4'd1);
        pulse_rst();
        out_ready_v[1] = 1'b0;
        repeat (8) send(1, 4'd1, 4'd1);
        wait_valid(1);
        pulse_rst();
        expect_sum(1, 8);
        out_ready_v[1] = 1'b1;
        repeat (8) send(1, 4'd1, 4'd1);
        wait_taken(1);

        repeat (3) @(posedge clk);
        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL summary_not_reached");
        $fatal(1, "compare process did not finish");
    end
endmodule
